// File: rtl/teamplayer_gen.sv
// Multi-pad nibble adapter for one Genesis port: snapshots up to eight pads and serialises them over TH/TR/TL.
// Optional abandoned-transfer recovery is built when TEAMPLAYER_TIMEOUT_EN is defined.
module teamplayer_gen #(
  parameter int          NUM_PORTS = 4,
  parameter logic [7:0]  PAD6_MASK = 8'hFF,
  parameter logic [9:0]  TIMEOUT   = 10'd1023
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      CE,
  input  logic [12*NUM_PORTS-1:0]   PAD,
  input  logic [NUM_PORTS-1:0]      PRESENT,
  input  logic                      TH,
  input  logic                      TR,
  output logic [3:0]                D,
  output logic                      TL,
  output logic                      BUSY
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t                    state;
  logic                      th_s, th_q, tr_s, tr_q;
  logic [12*NUM_PORTS-1:0]   pad_snap;
  logic [NUM_PORTS-1:0]      pres_snap;
  logic [5:0]                idx;
  logic [5:0]                idx_nxt;
  logic [5:0]                last_idx;
  logic [5:0]                pos;
  logic [11:0]               p;
  logic [3:0]                nib_next;
  logic                      th_fall, th_rise, tr_edge, tmo_hit;

  // Pins pass through th_s/tr_s first, so an edge is seen on the second CE tick.
  assign th_fall = th_q & ~th_s;
  assign th_rise = ~th_q & th_s;
  assign tr_edge = tr_s ^ tr_q;
  assign idx_nxt = idx + 6'd1;

  always_comb begin
    nib_next = 4'h0;
    pos      = 6'(3 + NUM_PORTS);
    p        = '0;
    for (int s = 0; s < NUM_PORTS; s++) begin
      p = pad_snap[12*s +: 12];
      if (idx_nxt == 6'(3 + s))
        nib_next = pres_snap[s] ? {3'b000, PAD6_MASK[s]} : 4'hF;
      if (pres_snap[s]) begin
        if (idx_nxt == pos)         nib_next = ~p[3:0];
        if (idx_nxt == pos + 6'd1)  nib_next = ~{p[7], p[4], p[6], p[5]};
        pos = pos + 6'd2;
        if (PAD6_MASK[s]) begin
          if (idx_nxt == pos) nib_next = ~{p[8], p[9], p[10], p[11]};
          pos = pos + 6'd1;
        end
      end
    end
    last_idx = pos - 6'd1;
  end

`ifdef TEAMPLAYER_TIMEOUT_EN
  logic [9:0] tmo_cnt;

  // Down-counter reloaded on session start and on every TR edge; expiry fires on the tick it would hit zero.
  assign tmo_hit = (state != IDLE) && !tr_edge && !th_rise && (tmo_cnt == 10'd1);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      tmo_cnt <= TIMEOUT;
    end else if (CE) begin
      if ((state == IDLE && th_fall) || (state != IDLE && tr_edge))
        tmo_cnt <= TIMEOUT;
      else if (state != IDLE && tmo_cnt != 10'd0)
        tmo_cnt <= tmo_cnt - 10'd1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      D         <= 4'h3;
      TL        <= 1'b1;
      BUSY      <= 1'b0;
      idx       <= 6'd0;
      pad_snap  <= '0;
      pres_snap <= '0;
      th_s      <= 1'b1;
      th_q      <= 1'b1;
      tr_s      <= 1'b1;
      tr_q      <= 1'b1;
    end else if (CE) begin
      th_s <= TH;
      th_q <= th_s;
      tr_s <= TR;
      tr_q <= tr_s;
      if (th_rise || tmo_hit) begin
        state <= IDLE;
        D     <= 4'h3;
        TL    <= 1'b1;
        BUSY  <= 1'b0;
        idx   <= 6'd0;
      end else begin
        case (state)
          IDLE: if (th_fall) begin
            pad_snap  <= PAD;
            pres_snap <= PRESENT;
            idx       <= 6'd0;
            D         <= 4'hF;
            TL        <= tr_s;
            BUSY      <= 1'b1;
            state     <= XFER;
          end
          XFER: if (tr_edge) begin
            idx <= idx_nxt;
            D   <= nib_next;
            TL  <= tr_s;
            if (idx_nxt == last_idx) state <= DONE;
          end
          DONE: if (tr_edge) begin
            D  <= 4'h0;
            TL <= tr_s;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_teamplayer_gen.sv
// Randomised bench for teamplayer_gen: two instances (3-button-only and mixed) checked against a queue-built stream model.
module tb_teamplayer_gen;

  localparam logic [7:0] M0 = 8'h00;
  localparam logic [7:0] M1 = 8'h04;

  logic        clk = 1'b0;
  logic        rst, ce, th, tr;
  logic [47:0] pad;
  logic [3:0]  present;
  logic [3:0]  d_o    [2];
  logic        tl_o   [2];
  logic        busy_o [2];

  int total = 0;
  int bad   = 0;

  logic [3:0] strm [2][0:39];
  int         len  [2];

  always #5 clk = ~clk;

  teamplayer_gen #(.NUM_PORTS(4), .PAD6_MASK(M0), .TIMEOUT(10'd16)) dut0 (
    .CLK(clk), .RESET(rst), .CE(ce), .PAD(pad), .PRESENT(present), .TH(th), .TR(tr),
    .D(d_o[0]), .TL(tl_o[0]), .BUSY(busy_o[0]));

  teamplayer_gen #(.NUM_PORTS(4), .PAD6_MASK(M1), .TIMEOUT(10'd16)) dut1 (
    .CLK(clk), .RESET(rst), .CE(ce), .PAD(pad), .PRESENT(present), .TH(th), .TR(tr),
    .D(d_o[1]), .TL(tl_o[1]), .BUSY(busy_o[1]));

  // Reference stream built straight from the protocol rules with a queue.
  task automatic build(input int u, input logic [47:0] pv, input logic [3:0] prv, input logic [7:0] mask);
    logic [3:0]  q[$];
    logic [11:0] b;
    logic up, dn, lf, rt, a, bb, c, st, md, x, y, z;
    q = {4'hF, 4'h0, 4'h0};
    for (int s = 0; s < 4; s++)
      q.push_back(!prv[s] ? 4'hF : (mask[s] ? 4'h1 : 4'h0));
    for (int s = 0; s < 4; s++) begin
      if (prv[s]) begin
        b  = pv[12*s +: 12];
        up = b[0]; dn = b[1]; lf = b[2]; rt = b[3]; a = b[4]; bb = b[5];
        c  = b[6]; st = b[7]; md = b[8]; x = b[9]; y = b[10]; z = b[11];
        q.push_back({~rt, ~lf, ~dn, ~up});
        q.push_back({~st, ~a, ~c, ~bb});
        if (mask[s]) q.push_back({~md, ~x, ~y, ~z});
      end
    end
    len[u] = q.size();
    for (int i = 0; i < 40; i++) strm[u][i] = (i < q.size()) ? q[i] : 4'h0;
  endtask

  function automatic logic [3:0] exp_nib(input int u, input int k);
    return (k < len[u]) ? strm[u][k] : 4'h0;
  endfunction

  // One CE tick, preceded by 0-2 frozen clocks; starts and ends at a falling edge.
  task automatic ce_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ce = 1'b1;
      @(negedge clk);
      ce = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; ce = 1'b0; th = 1'b1; tr = 1'b1; pad = '0; present = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int u = 0; u < 2; u++) begin
      total++;
      if (d_o[u] !== 4'h3 || tl_o[u] !== 1'b1 || busy_o[u] !== 1'b0) begin
        bad++;
        $display("FAIL reset dut%0d D=%h TL=%b BUSY=%b required D=3 TL=1 BUSY=0", u, d_o[u], tl_o[u], busy_o[u]);
      end
    end
    ce_ticks(4);
    for (int u = 0; u < 2; u++) begin
      total++;
      if (d_o[u] !== 4'h3 || tl_o[u] !== 1'b1 || busy_o[u] !== 1'b0) begin
        bad++;
        $display("FAIL idle dut%0d D=%h TL=%b BUSY=%b required D=3 TL=1 BUSY=0", u, d_o[u], tl_o[u], busy_o[u]);
      end
    end
  endtask

  task automatic run_session(input logic [47:0] pv, input logic [3:0] prv, input int ntog);
    pad = pv; present = prv;
    build(0, pv, prv, M0);
    build(1, pv, prv, M1);
    th = 1'b0;
    ce_ticks(1);
    for (int u = 0; u < 2; u++) begin
      total++;
      if (d_o[u] !== 4'h3 || busy_o[u] !== 1'b0) begin
        bad++;
        $display("FAIL start_latency dut%0d D=%h BUSY=%b required D=3 BUSY=0", u, d_o[u], busy_o[u]);
      end
    end
    ce_ticks(1);
    for (int u = 0; u < 2; u++) begin
      total++;
      if (d_o[u] !== 4'hF || tl_o[u] !== tr || busy_o[u] !== 1'b1) begin
        bad++;
        $display("FAIL start dut%0d D=%h TL=%b BUSY=%b required D=f TL=%b BUSY=1", u, d_o[u], tl_o[u], busy_o[u], tr);
      end
    end
    for (int k = 1; k <= ntog; k++) begin
      tr = ~tr;
      if (k == 3) begin
        pad = 48'({$urandom(), $urandom()});
        present = 4'($urandom());
      end
      ce_ticks(1);
      for (int u = 0; u < 2; u++) begin
        total++;
        if (d_o[u] !== exp_nib(u, k - 1) || tl_o[u] !== ~tr) begin
          bad++;
          $display("FAIL tr_latency dut%0d k=%0d D=%h TL=%b required D=%h TL=%b", u, k, d_o[u], tl_o[u], exp_nib(u, k - 1), ~tr);
        end
      end
      ce_ticks(1);
      for (int u = 0; u < 2; u++) begin
        total++;
        if (d_o[u] !== exp_nib(u, k) || tl_o[u] !== tr || busy_o[u] !== 1'b1) begin
          bad++;
          $display("FAIL stream dut%0d k=%0d D=%h TL=%b BUSY=%b required D=%h TL=%b BUSY=1", u, k, d_o[u], tl_o[u], busy_o[u], exp_nib(u, k), tr);
        end
      end
    end
    th = 1'b1;
    if ($urandom_range(0, 1) == 1) tr = ~tr;
    ce_ticks(2);
    for (int u = 0; u < 2; u++) begin
      total++;
      if (d_o[u] !== 4'h3 || tl_o[u] !== 1'b1 || busy_o[u] !== 1'b0) begin
        bad++;
        $display("FAIL th_rise dut%0d D=%h TL=%b BUSY=%b required D=3 TL=1 BUSY=0", u, d_o[u], tl_o[u], busy_o[u]);
      end
    end
  endtask

  task automatic test_directed;
    run_session({12'h000, 12'hF00, 12'h000, 12'h011}, 4'b0101, 13);
    run_session({12'h000, 12'hF00, 12'h000, 12'h011}, 4'b1111, 9);
  endtask

  task automatic test_random_sessions;
    for (int i = 0; i < 8; i++)
      run_session(48'({$urandom(), $urandom()}), 4'($urandom()), $urandom_range(0, 32));
  endtask

  task automatic test_back_to_back;
    run_session(48'({$urandom(), $urandom()}), 4'b1111, 5);
    run_session(48'({$urandom(), $urandom()}), 4'b1011, 5);
    run_session(48'({$urandom(), $urandom()}), 4'b0110, 20);
  endtask

  task automatic test_freeze_and_reset;
    logic tl_old;
    pad = 48'({$urandom(), $urandom()}); present = 4'b1111;
    build(0, pad, present, M0);
    build(1, pad, present, M1);
    th = 1'b0;
    ce_ticks(2);
    for (int k = 1; k <= 9; k++) begin
      tr = ~tr;
      ce_ticks(2);
    end
    tl_old = tr;
    tr = ~tr;
    repeat (6) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      total++;
      if (d_o[u] !== exp_nib(u, 9) || tl_o[u] !== tl_old || busy_o[u] !== 1'b1) begin
        bad++;
        $display("FAIL ce_freeze dut%0d D=%h TL=%b BUSY=%b required D=%h TL=%b BUSY=1", u, d_o[u], tl_o[u], busy_o[u], exp_nib(u, 9), tl_old);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int u = 0; u < 2; u++) begin
      total++;
      if (d_o[u] !== 4'h3 || tl_o[u] !== 1'b1 || busy_o[u] !== 1'b0) begin
        bad++;
        $display("FAIL reset_mid dut%0d D=%h TL=%b BUSY=%b required D=3 TL=1 BUSY=0", u, d_o[u], tl_o[u], busy_o[u]);
      end
    end
    th = 1'b1; tr = 1'b1;
    ce_ticks(3);
  endtask

  task automatic test_timeout;
    pad = 48'({$urandom(), $urandom()}); present = 4'b1111;
    build(0, pad, present, M0);
    build(1, pad, present, M1);
    th = 1'b0;
    ce_ticks(2);
    tr = ~tr;
    ce_ticks(2);
`ifdef TEAMPLAYER_TIMEOUT_EN
    ce_ticks(15);
    for (int u = 0; u < 2; u++) begin
      total++;
      if (busy_o[u] !== 1'b1 || d_o[u] !== exp_nib(u, 1)) begin
        bad++;
        $display("FAIL tmo_early dut%0d D=%h BUSY=%b required D=%h BUSY=1", u, d_o[u], busy_o[u], exp_nib(u, 1));
      end
    end
    ce_ticks(1);
    for (int u = 0; u < 2; u++) begin
      total++;
      if (d_o[u] !== 4'h3 || tl_o[u] !== 1'b1 || busy_o[u] !== 1'b0) begin
        bad++;
        $display("FAIL tmo_abort dut%0d D=%h TL=%b BUSY=%b required D=3 TL=1 BUSY=0", u, d_o[u], tl_o[u], busy_o[u]);
      end
    end
    tr = ~tr;
    ce_ticks(3);
    for (int u = 0; u < 2; u++) begin
      total++;
      if (d_o[u] !== 4'h3 || tl_o[u] !== 1'b1 || busy_o[u] !== 1'b0) begin
        bad++;
        $display("FAIL tmo_tr_ignored dut%0d D=%h TL=%b BUSY=%b required D=3 TL=1 BUSY=0", u, d_o[u], tl_o[u], busy_o[u]);
      end
    end
`else
    ce_ticks(40);
    for (int u = 0; u < 2; u++) begin
      total++;
      if (busy_o[u] !== 1'b1 || d_o[u] !== exp_nib(u, 1)) begin
        bad++;
        $display("FAIL no_tmo_hold dut%0d D=%h BUSY=%b required D=%h BUSY=1", u, d_o[u], busy_o[u], exp_nib(u, 1));
      end
    end
    tr = ~tr;
    ce_ticks(2);
    for (int u = 0; u < 2; u++) begin
      total++;
      if (d_o[u] !== exp_nib(u, 2) || tl_o[u] !== tr) begin
        bad++;
        $display("FAIL no_tmo_resume dut%0d D=%h TL=%b required D=%h TL=%b", u, d_o[u], tl_o[u], exp_nib(u, 2), tr);
      end
    end
`endif
    th = 1'b1;
    ce_ticks(2);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random_sessions();
    test_back_to_back();
    test_freeze_and_reset();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
